// File: rtl/ugv_cmd_sequencer.sv
// UGV drive-command sequencer: synchronizes pushbutton requests, arbitrates them,
// enforces dwell and stop dead-time, with estop override. Optional watchdog: UGV_WATCHDOG_EN.
module ugv_cmd_sequencer #(
  parameter int DWELL_CYCLES    = 10000000,
  parameter int DEADTIME_CYCLES = 2000000,
  parameter int MAX_RUN_CYCLES  = 100000000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  input  logic       estop,
  output logic [3:0] control,
  output logic [1:0] state,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10, HALT = 2'b11} st_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEADTIME_CYCLES - 1);

  st_t              st;
  logic [3:0]       btn_s1, req, cmd, sel;
  logic             es_s1, es_s2;
  logic [CNT_W-1:0] cnt;
  logic             wd_trip, can_start;

  // Fixed priority: forward > backward > left > right.
  always_comb begin
    sel = 4'b0000;
    if (req[1])      sel = 4'b0010;
    else if (req[0]) sel = 4'b0001;
    else if (req[3]) sel = 4'b1000;
    else if (req[2]) sel = 4'b0100;
  end

  assign state = st;

`ifdef UGV_WATCHDOG_EN
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_RUN_CYCLES - 1);
  logic [CNT_W-1:0] run_cnt;
  logic             timeout_q, rel_seen;
  assign wd_trip   = (run_cnt == RUN_LAST);
  // After a trip the same command needs an operator release before restarting.
  assign can_start = (sel != 4'b0000) && (!timeout_q || rel_seen || (sel != cmd));
  assign timeout   = timeout_q;
`else
  assign wd_trip   = 1'b0;
  assign can_start = (sel != 4'b0000);
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1  <= '0;
      req     <= '0;
      es_s1   <= 1'b0;
      es_s2   <= 1'b0;
      st      <= IDLE;
      cmd     <= '0;
      cnt     <= '0;
      control <= '0;
      busy    <= 1'b0;
`ifdef UGV_WATCHDOG_EN
      run_cnt   <= '0;
      timeout_q <= 1'b0;
      rel_seen  <= 1'b0;
`endif
    end else begin
      btn_s1 <= btn_in;
      req    <= btn_s1;
      es_s1  <= estop;
      es_s2  <= es_s1;
`ifdef UGV_WATCHDOG_EN
      if (timeout_q && sel == 4'b0000) rel_seen <= 1'b1;
      if (st == RUN) run_cnt <= run_cnt + CNT_W'(1);
`endif
      if (es_s2) begin
        st      <= HALT;
        control <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            if (can_start) begin
              st      <= RUN;
              cmd     <= sel;
              control <= sel;
              cnt     <= '0;
              busy    <= 1'b1;
`ifdef UGV_WATCHDOG_EN
              run_cnt   <= '0;
              timeout_q <= 1'b0;
              rel_seen  <= 1'b0;
`endif
            end
          end
          RUN: begin
            if (wd_trip) begin
              st      <= DEAD;
              control <= '0;
              cnt     <= '0;
`ifdef UGV_WATCHDOG_EN
              timeout_q <= 1'b1;
              rel_seen  <= 1'b0;
`endif
            end else if (cnt == DWELL_LAST) begin
              // Dwell satisfied: hold while the same command is still the winner.
              if (sel != cmd) begin
                st      <= DEAD;
                control <= '0;
                cnt     <= '0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DEAD: begin
            if (cnt == DEAD_LAST) begin
              st   <= IDLE;
              cnt  <= '0;
              busy <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HALT: begin
            st      <= DEAD;
            cnt     <= '0;
            control <= '0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
